// File: rtl/ssd_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ssd_display_scheduler
// Purpose  : Converts a binary result to four BCD digits (one bit per clock,
//            shift-and-add-3), commits the digits atomically, and scans them
//            onto a 4-digit active-low seven-segment display with optional
//            leading-zero blanking.
// Ports    : clk         - system clock, rising edge
//            reset       - asynchronous active-low reset
//            value       - binary value to display
//            value_valid - conversion request, sampled every rising edge
//            busy        - high while a conversion is in progress
//            done        - one-cycle pulse when new digits are committed
//            Anode       - active-low digit enables, bit 3 = thousands
//            LED_out     - active-low segments abcdefg, a = bit 6
// Revision : 1.0 - initial release
// ============================================================================
module ssd_display_scheduler #(
  parameter int DATA_W       = 13,
  parameter int REFRESH_BITS = 20,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] value,
  input  logic              value_valid,
  output logic              busy,
  output logic              done,
  output logic [3:0]        Anode,
  output logic [6:0]        LED_out
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BCD_W = 16;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SHIFT  = 2'd1;
  localparam logic [1:0] c_COMMIT = 2'd2;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_W - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]              state_q,   state_d;
  logic [DATA_W-1:0]       shift_q,   shift_d;
  logic [BCD_W-1:0]        bcd_q,     bcd_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic                    pend_q,    pend_d;
  logic [DATA_W-1:0]       pendv_q,   pendv_d;
  logic [BCD_W-1:0]        digits_q,  digits_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;
  logic [REFRESH_BITS-1:0] refresh_q;

  // --------------------------------------------------------------------------
  // Add-3 correction: every nibble is adjusted in parallel before the shift
  // --------------------------------------------------------------------------
  logic [BCD_W-1:0]          w_bcd_adj;
  logic [BCD_W+DATA_W-1:0]   w_cat_shl;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_adj
    assign w_bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_q[gi*4 +: 4] + 4'd3) :
                                  bcd_q[gi*4 +: 4];
  end

  // {BCD, shift} moved left as one word; the shift MSB enters the BCD LSB
  assign w_cat_shl = {w_bcd_adj, shift_q} << 1;

  // --------------------------------------------------------------------------
  // Conversion FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pendv_d  = pendv_q;
    digits_d = digits_q;
    done_d   = 1'b0;

    case (state_q)
      c_IDLE: begin
        if (value_valid) begin
          shift_d = value;
          bcd_d   = '0;
          cnt_d   = c_CNT_LAST;
          state_d = c_SHIFT;
        end
      end

      c_SHIFT: begin
        bcd_d   = w_cat_shl[BCD_W+DATA_W-1:DATA_W];
        shift_d = w_cat_shl[DATA_W-1:0];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = c_COMMIT;
        end
        // One-deep pending slot; a later request overwrites an earlier one
        if (value_valid) begin
          pend_d  = 1'b1;
          pendv_d = value;
        end
      end

      c_COMMIT: begin
        digits_d = bcd_q;
        done_d   = 1'b1;
        if (value_valid) begin
          // Newest request wins; anything parked in the pending slot is stale
          shift_d = value;
          bcd_d   = '0;
          cnt_d   = c_CNT_LAST;
          pend_d  = 1'b0;
          state_d = c_SHIFT;
        end else if (pend_q) begin
          shift_d = pendv_q;
          bcd_d   = '0;
          cnt_d   = c_CNT_LAST;
          pend_d  = 1'b0;
          state_d = c_SHIFT;
        end else begin
          state_d = c_IDLE;
        end
      end

      default: begin
        state_d = c_IDLE;
      end
    endcase

    busy_d = (state_d != c_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= c_IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      pendv_q  <= '0;
      digits_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pendv_q  <= pendv_d;
      digits_q <= digits_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // --------------------------------------------------------------------------
  // Refresh counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
    end else begin
      refresh_q <= refresh_q + REFRESH_BITS'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Digit scan and segment decode
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  logic [1:0] w_sel;
  logic [3:0] w_th, w_hun, w_ten, w_one;
  logic [3:0] w_digit;
  logic       w_blank;

  assign w_sel = refresh_q[REFRESH_BITS-1 -: 2];
  assign w_th  = digits_q[15:12];
  assign w_hun = digits_q[11:8];
  assign w_ten = digits_q[7:4];
  assign w_one = digits_q[3:0];

  always_comb begin
    Anode   = 4'b1111;
    w_digit = 4'd0;
    w_blank = 1'b0;
    case (w_sel)
      2'd0: begin
        Anode   = 4'b0111;
        w_digit = w_th;
        w_blank = (w_th == 4'd0);
      end
      2'd1: begin
        Anode   = 4'b1011;
        w_digit = w_hun;
        w_blank = (w_th == 4'd0) && (w_hun == 4'd0);
      end
      2'd2: begin
        Anode   = 4'b1101;
        w_digit = w_ten;
        w_blank = (w_th == 4'd0) && (w_hun == 4'd0) && (w_ten == 4'd0);
      end
      default: begin
        Anode   = 4'b1110;
        w_digit = w_one;
        w_blank = 1'b0;
      end
    endcase
    LED_out = (BLANK_LZ && w_blank) ? 7'b1111111 : seg7(w_digit);
  end

endmodule
`default_nettype wire

// File: tb/tb_ssd_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_display_scheduler
// Purpose  : Self-checking bench; two instances (blanking on / off) share the
//            same stimulus and are compared every cycle against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_display_scheduler;

  localparam int DATA_W       = 13;
  localparam int REFRESH_BITS = 4;
  localparam int LATENCY      = DATA_W + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] value;
  logic              value_valid;

  logic       busy_b, done_b, busy_n, done_n;
  logic [3:0] anode_b, anode_n;
  logic [6:0] led_b, led_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ssd_display_scheduler #(
    .DATA_W(DATA_W), .REFRESH_BITS(REFRESH_BITS), .BLANK_LZ(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .busy(busy_b), .done(done_b), .Anode(anode_b), .LED_out(led_b)
  );

  ssd_display_scheduler #(
    .DATA_W(DATA_W), .REFRESH_BITS(REFRESH_BITS), .BLANK_LZ(1'b0)
  ) u_dut_n (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .busy(busy_n), .done(done_n), .Anode(anode_n), .LED_out(led_n)
  );

  // --------------------------------------------------------------------------
  // Reference model: a conversion is a countdown of LATENCY edges after
  // acceptance, ending in a commit of the decimal value.
  // --------------------------------------------------------------------------
  bit m_active, m_done, m_pend;
  int m_rem, m_cur, m_pval, m_num, m_ref;

  always @(posedge clk) begin
    if (!reset) begin
      m_active = 0; m_done = 0; m_pend = 0;
      m_rem = 0; m_cur = 0; m_pval = 0; m_num = 0; m_ref = 0;
    end else begin
      m_ref  = (m_ref + 1) % (1 << REFRESH_BITS);
      m_done = 0;
      if (m_active) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_num  = m_cur;
          m_done = 1;
          if (value_valid) begin
            m_cur = int'(value); m_rem = LATENCY; m_pend = 0;
          end else if (m_pend) begin
            m_cur = m_pval; m_rem = LATENCY; m_pend = 0;
          end else begin
            m_active = 0;
          end
        end else if (value_valid) begin
          m_pend = 1; m_pval = int'(value);
        end
      end else if (value_valid) begin
        m_active = 1; m_cur = int'(value); m_rem = LATENCY;
      end
    end
  end

  function automatic logic [6:0] exp_led(input int num, input int sel, input bit blank);
    int d;
    case (sel)
      0:       d = num / 1000;
      1:       d = (num / 100) % 10;
      2:       d = (num / 10) % 10;
      default: d = num % 10;
    endcase
    if (blank && ((sel == 0 && num < 1000) || (sel == 1 && num < 100) ||
                  (sel == 2 && num < 10)))
      return 7'b1111111;
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int         sel;
    logic [3:0] an;
    sel = m_ref / (1 << (REFRESH_BITS - 2));
    an  = ~(4'b1000 >> sel);
    check_val("busy_b",  32'(busy_b),  32'(m_active));
    check_val("done_b",  32'(done_b),  32'(m_done));
    check_val("anode_b", 32'(anode_b), 32'(an));
    check_val("led_b",   32'(led_b),   32'(exp_led(m_num, sel, 1'b1)));
    check_val("busy_n",  32'(busy_n),  32'(m_active));
    check_val("done_n",  32'(done_n),  32'(m_done));
    check_val("anode_n", 32'(anode_n), 32'(an));
    check_val("led_n",   32'(led_n),   32'(exp_led(m_num, sel, 1'b0)));
  endtask

  // Drive one cycle of inputs, then check after the following rising edge
  task automatic step(input logic r, input logic vv, input int v);
    reset       = r;
    value_valid = vv;
    value       = DATA_W'(v);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b0; value_valid = 1'b0; value = '0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
    idle(20);

    // Single conversion
    step(1'b1, 1'b1, 1234); idle(20);

    // Full-scale then a small value that exercises blanking
    step(1'b1, 1'b1, 8191); idle(18);
    step(1'b1, 1'b1, 7);    idle(18);

    // Pending overwrite while shifting
    step(1'b1, 1'b1, 500); idle(3);
    step(1'b1, 1'b1, 42);  idle(2);
    step(1'b1, 1'b1, 77);  idle(36);

    // Back-to-back request landing exactly in the commit cycle
    step(1'b1, 1'b1, 9); idle(DATA_W);
    step(1'b1, 1'b1, 3); idle(20);

    // Reset mid-conversion, then a fresh conversion
    step(1'b1, 1'b1, 4321); idle(6);
    step(1'b0, 1'b0, 0); step(1'b0, 1'b1, 99);
    idle(5);
    step(1'b1, 1'b1, 15); idle(20);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, vv;
      int   v;
      r  = ($urandom_range(0, 599) != 0);
      vv = ($urandom_range(0, 5) == 0);
      v  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 120))
                                        : int'($urandom_range(0, 8191));
      step(r, vv, v);
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ssd_display_scheduler.md
Name: ssd_display_scheduler

Overview:
- Sequences display of a 13-bit processor result on the board's 4-digit seven-segment display.
- Performs an iterative binary-to-BCD conversion, one bit per clock, with a start/busy/done handshake.
- Commits converted digits atomically.
- Time-multiplexes the four anodes from a free-running refresh counter, with optional leading-zero blanking.

Parameters:
- DATA_W, 13, width of the binary input value. Maximum 8191; four digits always suffice.
- REFRESH_BITS, 20, refresh counter width. Digit select = counter[REFRESH_BITS-1:REFRESH_BITS-2].
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all four digits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- value  in  DATA_W  binary value to display.
- value_valid  in  1  conversion request, sampled every rising edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- Anode  out  4  active-low digit enable; bit 3 = thousands.
- LED_out  out  7  active-low segments abcdefg, a = bit 6.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, busy=0, done=0, pending flag=0.
  - Shift and BCD registers = 0; committed digits th/hun/ten/one = 0.
  - Refresh counter = 0, so Anode=0111.
  - LED_out = 1111111 when BLANK_LZ=1, else 0000001.
  - Reset mid-conversion aborts it. No done pulse; committed digits read 0.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - If value_valid=1, capture value into the shift register, clear BCD working registers, bit counter=DATA_W-1, go to SHIFT.
- SHIFT (one bit per cycle):
  - Each BCD nibble >=5 gets +3 (all four nibbles evaluated in parallel, before the shift).
  - Then shift {BCD, shift register} left by 1, inserting the MSB of the shift register.
  - Decrement the counter. After DATA_W SHIFT cycles, go to COMMIT.
- COMMIT (one cycle):
  - Copy working BCD to committed digits; done=1 for this cycle only.
  - If value_valid=1 this cycle, load that value and go to SHIFT (newest wins; pending discarded).
  - Else if pending=1, load the pending value, clear pending, go to SHIFT.
  - Otherwise go to IDLE.
- busy = 1 in SHIFT and COMMIT; registered output.
- Latency: value_valid sampled at edge k → done high for cycle after edge k+DATA_W+1 (14 cycles for DATA_W=13). Committed digits change on the same edge that raises done.
- Requests while busy (SHIFT):
  - value_valid=1 stores value into a one-deep pending register and sets pending.
  - Later requests overwrite the stored value (latest wins). No request is dropped silently except by overwrite.
- Committed digits are stable between done pulses. The display never shows partially converted data.
- Refresh counter:
  - Free-running, increments every cycle, wraps from all-ones to 0.
  - sel 00 → Anode 0111, thousands.
  - sel 01 → Anode 1011, hundreds.
  - sel 10 → Anode 1101, tens.
  - sel 11 → Anode 1110, ones.
  - Anode and LED_out are combinational from sel and committed digits.
- Segment codes, digits 0-9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. Any other nibble → 0000001.
- Blanking (BLANK_LZ=1):
  - Thousands blank if th=0.
  - Hundreds blank if th=0 and hun=0.
  - Tens blank if th, hun and ten are all 0.
  - Ones are never blanked.
  - Blank = LED_out 1111111; Anode is still driven normally.
- Simultaneous reset and value_valid: reset wins.

Test Plan:
- Reset, then hold reset=1 with no requests → busy=0, done=0. Anode cycles 0111,1011,1101,1110 and wraps (REFRESH_BITS=4: one change per 4 cycles). LED_out=1111111 except the ones slot shows 0000001.
- value=1234, value_valid for 1 cycle → busy high, done pulse exactly 14 cycles later. Digits 1,2,3,4 → LED_out 1001111, 0010010, 0000110, 1001100 in their slots.
- value=8191 then value=7 (BLANK_LZ=1) → first gives 8,1,9,1. Second gives thousands, hundreds and tens 1111111, ones 0001111. With BLANK_LZ=0 it shows 0,0,0,7.
- Request 500; during SHIFT request 42, then 77 → two done pulses. First commits 0500; second commits 0077 (42 overwritten); busy continuous across both.
- Request 9, then value_valid again exactly in the COMMIT cycle with value=3 → done pulses for 9 and then for 3. No IDLE cycle between them.
- Request 4321, assert reset at SHIFT cycle 6, release → no done pulse, digits 0,0,0,0, state IDLE. A new request for 15 converts correctly to 0015.
